// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family.
//
// Contents:
//   DIR_DOWN / DIR_UP    - encodings of the dir input
//   MODE_WRAP / MODE_SAT - encodings of the sat input
//   GRAY_MAX_W           - widest count handled by bin2gray
//   bin2gray()           - binary to reflected Gray code, width-generic
//
// bin2gray works on a GRAY_MAX_W-bit container. Callers zero-extend
// their value in and size-cast the result back down to their own width.
// Zero-extension is safe because the upper Gray bits of a zero-extended
// value are all zero, so the low WIDTH bits are exactly the WIDTH-bit
// Gray code.
package gray_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_prescaler.sv
// Enable-gated prescaler for gray_counter_gen.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, clears the count
//   en     in   count enable; 0 freezes the count
//   clr    in   synchronous restart of the count (used on counter load)
//   presc  in   divide ratio; tick fires every presc+1 enabled cycles
//   tick   out  combinational step strobe for the current cycle
//
// tick is en & (pcnt == presc). The comparison always uses the current
// presc, so lowering presc below the running count does not fire an
// early tick: the count runs on through 2^PRESCALE_W and wraps to 0
// before it can match again.
module gray_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_q;
  logic [PRESCALE_W-1:0] pcnt_d;

  always_comb begin
    tick   = en & (pcnt_q == presc);
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else if (en) begin
      // Natural modulo-2^PRESCALE_W wrap is intended here.
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/gray_counter_gen.sv
// Parametrised, prescaled Gray-code counter.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   count enable; 0 freezes prescaler and counter
//   dir        in   1 = count up, 0 = count down
//   sat        in   0 = wrap at the bounds, 1 = saturate at the bounds
//   load       in   synchronous load strobe
//   load_val   in   binary value to load
//   presc      in   divide ratio; one step every presc+1 enabled cycles
//   gray       out  registered Gray code of the count
//   bin        out  registered binary count
//   tc         out  registered one-cycle terminal-count pulse
//   slow_bits  out  top SLOW_N bits of gray
//   fast_bits  out  bottom FAST_N bits of gray
//
// Edge priority: rst > load > tick > hold. A load discards a coincident
// tick and restarts the prescaler. tc pulses on every tick that hits a
// bound: a wrap in wrap mode, or a blocked step in saturate mode (which
// repeats on each blocked tick). This block has no handshake; every
// input is sampled on each rising edge and outputs are pure registers.
module gray_counter_gen
  import gray_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4,
  parameter int SLOW_N     = 5,
  parameter int FAST_N     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  sat,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] presc,
  output logic [WIDTH-1:0]      gray,
  output logic [WIDTH-1:0]      bin,
  output logic                  tc,
  output logic [SLOW_N-1:0]     slow_bits,
  output logic [FAST_N-1:0]     fast_bits
);

  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_MIN = '0;

  logic             tick;
  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q,   tc_d;
  logic             at_bound;
  logic             up;

  gray_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (load),
    .presc (presc),
    .tick  (tick)
  );

  always_comb begin
    up       = (dir == DIR_UP);
    at_bound = up ? (bin_q == BIN_MAX) : (bin_q == BIN_MIN);
    bin_d    = bin_q;
    tc_d     = 1'b0;

    if (load) begin
      bin_d = load_val;
    end else if (tick) begin
      if (at_bound) begin
        // Both a wrap and a blocked saturated step count as terminal.
        tc_d = 1'b1;
        if (sat == MODE_SAT) begin
          bin_d = bin_q;
        end else begin
          bin_d = up ? BIN_MIN : BIN_MAX;
        end
      end else begin
        bin_d = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
      end
    end

    // Gray is derived from the next binary value so both land on the
    // same edge with no extra cycle of latency.
    gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin       = bin_q;
  assign gray      = gray_q;
  assign tc        = tc_q;
  assign slow_bits = gray_q[WIDTH-1 -: SLOW_N];
  assign fast_bits = gray_q[FAST_N-1:0];

endmodule
